// File: rtl/conv_sequencer.sv
// conv_sequencer: runs one k*k streaming-convolver pass over an N*N feature map.
// Define CONV_SEQ_RELU_EN to clamp negative results to zero at capture.
module conv_sequencer #(
  parameter int N  = 10,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fm_rd,
  output logic [AW-1:0] fm_addr,
  input  logic [15:0]   fm_data,
  output logic          conv_rst,
  output logic          conv_ce,
  output logic [15:0]   conv_act,
  input  logic [32:0]   conv_op,
  input  logic          conv_valid,
  input  logic          conv_end,
  output logic          out_wr,
  output logic [AW-1:0] out_addr,
  output logic [32:0]   out_data,
  input  logic          out_ready
);
  localparam int ODIM = (N - K) / S + 1;
  localparam int OTOT = ODIM * ODIM;
  localparam int NN   = N * N;
  localparam int CW   = $clog2(NN + 1);
  localparam logic [AW-1:0] LAST = AW'(NN - 1);
  localparam logic [CW-1:0] WEND = CW'(OTOT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_conv_rst;
  logic          r_rd_en;
  logic [AW-1:0] r_addr;
  logic          r_rd_q;
  logic [15:0]   r_skid;
  logic          r_skid_v;
  logic [32:0]   r_res;
  logic          r_pend;
  logic [AW-1:0] r_oaddr;
  logic [CW-1:0] r_wcnt;

  logic          w_stall;
  logic          w_cap;
  logic          w_wr;
  logic [32:0]   w_res;
  logic          w_unused;

  assign w_unused = conv_end;
  assign w_stall  = r_pend & ~out_ready;
  assign w_wr     = r_pend & out_ready;
  assign w_cap    = conv_ce & conv_valid;

  assign busy     = r_busy;
  assign done     = r_done;
  assign conv_rst = r_conv_rst;
  assign fm_rd    = r_rd_en & ~w_stall;
  assign fm_addr  = r_addr;
  assign conv_ce  = (r_rd_q | r_skid_v) & ~w_stall;
  assign conv_act = r_skid_v ? r_skid :
                    r_rd_q   ? fm_data : '0;
  assign out_wr   = r_pend;
  assign out_addr = r_oaddr;
  assign out_data = r_res;

`ifdef CONV_SEQ_RELU_EN
  assign w_res = conv_op[32] ? '0 : conv_op;
`else
  assign w_res = conv_op;
`endif

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_conv_rst <= 1'b0;
      r_rd_en    <= 1'b0;
      r_addr     <= '0;
      r_rd_q     <= 1'b0;
      r_skid     <= '0;
      r_skid_v   <= 1'b0;
      r_res      <= '0;
      r_pend     <= 1'b0;
      r_oaddr    <= '0;
      r_wcnt     <= '0;
    end else begin
      r_rd_q <= fm_rd;
      // a read landing during a stall is parked until the stall clears
      if (r_rd_q && w_stall) begin
        r_skid   <= fm_data;
        r_skid_v <= 1'b1;
      end else if (!w_stall) begin
        r_skid_v <= 1'b0;
      end
      if (w_cap) begin
        r_res  <= w_res;
        r_pend <= 1'b1;
      end else if (w_wr) begin
        r_pend <= 1'b0;
      end
      if (w_wr) begin
        r_oaddr <= r_oaddr + 1'b1;
        r_wcnt  <= r_wcnt + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_conv_rst <= 1'b1;
            r_addr     <= '0;
            r_oaddr    <= '0;
            r_wcnt     <= '0;
          end
        end
        S_CLEAR: begin
          r_conv_rst <= 1'b0;
          r_rd_en    <= 1'b1;
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          if (fm_rd) begin
            if (r_addr == LAST) begin
              r_rd_en <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_wcnt == WEND && !r_pend) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
